fetch_prefetch_queue: RTL and testbench
=======================================

FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: queue entries and maximum in-flight fetches; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits[1:0] are zero.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low; asserted (0) sampled on a rising clk edge resets the block.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_addr  output  32  word-aligned fetch address.
REQ-007 imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 imem_rsp_valid  input  1  in-order response valid; no backpressure.
REQ-009 imem_rsp_data  input  32  instruction word for oldest unanswered request.
REQ-010 redirect  input  1  branch/jump flush; discard all queued and in-flight fetches.
REQ-011 redirect_pc  input  32  new fetch address; bits[1:0] ignored (treated as 0).
REQ-012 out_valid  output  1  head instruction available to decode.
REQ-013 out_pc  output  32  PC of head instruction.
REQ-014 out_instr  output  32  head instruction word.
REQ-015 out_ready  input  1  decode accepts head (low = decode stall).
REQ-016 occupancy  output  clog2(DEPTH)+1  allocated entries (filled plus awaiting response).
REQ-017 protocol_err  output  1  sticky: response arrived with no request outstanding.

Function
REQ-018 Queue: DEPTH entries {pc, instr, filled}; pointers head (pop), fill (next response), tail (next allocation), all wrapping modulo DEPTH.
REQ-019 Entry state per slot: FREE -> PENDING (request accepted) -> FILLED (response written) -> FREE (popped or redirect).
REQ-020 drop_cnt register, 0..DEPTH: responses still owed for requests discarded by redirect.
REQ-021 imem_req_valid = 1 iff reset deasserted, redirect = 0, and occupancy + drop_cnt < DEPTH; imem_req_addr = fetch_pc.
REQ-022 Request handshake (valid & ready): slot tail becomes PENDING with pc = fetch_pc; tail++; fetch_pc += 4 (mod 2^32 wrap).
REQ-023 imem_req_valid and imem_req_addr remain stable while imem_req_ready is low, unless redirect intervenes.
REQ-024 Response with drop_cnt > 0: data discarded, drop_cnt decrements; no queue change.
REQ-025 Response with drop_cnt = 0 and a PENDING slot: slot fill gets instr = imem_rsp_data and becomes FILLED; fill++.
REQ-026 Response with drop_cnt = 0 and no PENDING slot: data discarded; protocol_err set until reset.
REQ-027 out_valid = slot head FILLED; out_pc/out_instr come from slot head; registered state, no combinational path from imem_rsp_* to out_*.
REQ-028 Response-to-out_valid latency is one cycle when the entry is at head.
REQ-029 Pop (out_valid & out_ready): slot head FREE, head++; same-cycle pop, allocation and fill all take effect independently.
REQ-030 out_pc/out_instr hold stable while out_valid = 1 and out_ready = 0.
REQ-031 Redirect (priority over all same-cycle events): all slots FREE; head = fill = tail = 0; fetch_pc = {redirect_pc[31:2], 2'b00}.
REQ-032 On redirect, drop_cnt_next = drop_cnt + (PENDING count) - (imem_rsp_valid ? 1 : 0); a same-cycle response counts against that total.
REQ-033 Redirect cycle: no request issued and no pop; out_valid = 0 in the following cycle.
REQ-034 Back-to-back redirects accumulate drop_cnt per REQ-032; drop_cnt never exceeds DEPTH.
REQ-035 Full condition (occupancy + drop_cnt = DEPTH): imem_req_valid = 0 until a pop or drop frees credit; the request may reassert in the same cycle credit frees.

Reset
REQ-036 While reset = 0 at a clk edge, next state is: fetch_pc = RESET_PC; head/fill/tail/drop_cnt = 0; all slots FREE; protocol_err = 0.
REQ-037 Outputs while in reset: imem_req_valid = 0, out_valid = 0, occupancy = 0, protocol_err = 0.
REQ-038 Reset mid-operation abandons in-flight fetches without drop tracking; the memory model is also reset.
REQ-039 First request is presented in the cycle after reset releases, at RESET_PC.

Verification
REQ-040 Streaming: DEPTH=4, req_ready = 1, responses 1 cycle later, out_ready = 1 -> out_pc sequence 0x0, 0x4, 0x8, ... with one instruction per cycle in steady state.
REQ-041 Decode stall: out_ready = 0 for 10 cycles -> 4 requests issued, then imem_req_valid = 0 with occupancy = 4; out_pc = 0x0 held; after release, pops resume in order.
REQ-042 Redirect in flight: 3 PENDING, redirect_pc = 0x103 -> next request at 0x100; 3 stale responses dropped; first out_pc = 0x100.
REQ-043 Redirect with same-cycle response: 2 PENDING plus rsp_valid on the redirect cycle -> drop_cnt = 1; only 1 later response discarded.
REQ-044 Memory backpressure: req_ready low 5 cycles -> imem_req_addr stable at 0x8 throughout, with no duplicate or lost PCs.
REQ-045 Spurious response with nothing outstanding -> protocol_err = 1 and stays set; reset (0 for one cycle) clears it, and the next request is at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - instruction prefetch queue with in-order memory responses and redirect flush
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req_valid,
    output logic [31:0]              imem_req_addr,
    input  logic                     imem_req_ready,
    input  logic                     imem_rsp_valid,
    input  logic [31:0]              imem_rsp_data,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     protocol_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_PENDING,
        SLOT_FILLED
    } slot_e;

    slot_e           slot_q  [DEPTH];
    logic [31:0]     pc_q    [DEPTH];
    logic [31:0]     instr_q [DEPTH];
    logic [AW-1:0]   head_q;
    logic [AW-1:0]   fill_q;
    logic [AW-1:0]   tail_q;
    logic [CW-1:0]   occ_q;
    logic [CW-1:0]   pend_q;
    logic [CW-1:0]   drop_q;
    logic [31:0]     fetch_pc_q;
    logic            err_q;

    logic            pop;
    logic            req_fire;
    logic            rsp_drop;
    logic            rsp_fill;
    logic            rsp_spur;
    logic [CW:0]     used;
    logic [CW-1:0]   owed;
    logic [CW-1:0]   redir_drop;
    logic            redir_spur;
    logic            unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    always_comb begin
        out_valid  = reset && !redirect && (slot_q[head_q] == SLOT_FILLED);
        out_pc     = pc_q[head_q];
        out_instr  = instr_q[head_q];
        pop        = out_valid && out_ready;

        rsp_drop   = imem_rsp_valid && (drop_q != '0);
        rsp_fill   = imem_rsp_valid && (drop_q == '0) && (pend_q != '0);
        rsp_spur   = imem_rsp_valid && (drop_q == '0) && (pend_q == '0);

        // Credit released this cycle by a pop or a dropped response can be reused at once.
        used = {1'b0, occ_q} + {1'b0, drop_q}
             - {{CW{1'b0}}, pop} - {{CW{1'b0}}, rsp_drop};
        imem_req_valid = reset && !redirect && (used < DEPTH_W);
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;

        // Responses still owed after a flush; one arriving this cycle is already paid.
        owed       = drop_q + pend_q;
        redir_spur = imem_rsp_valid && (owed == '0);
        redir_drop = owed;
        if (imem_rsp_valid && (owed != '0)) begin
            redir_drop = owed - 1'b1;
        end

        occupancy    = reset ? occ_q : '0;
        protocol_err = reset && err_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= SLOT_FREE;
            end
            head_q     <= '0;
            fill_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            pend_q     <= '0;
            drop_q     <= '0;
            fetch_pc_q <= RESET_PC;
            err_q      <= 1'b0;
        end else if (redirect) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= SLOT_FREE;
            end
            head_q     <= '0;
            fill_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            pend_q     <= '0;
            drop_q     <= redir_drop;
            fetch_pc_q <= {redirect_pc[31:2], 2'b00};
            if (redir_spur) begin
                err_q <= 1'b1;
            end
        end else begin
            if (pop) begin
                slot_q[head_q] <= SLOT_FREE;
                head_q         <= head_q + 1'b1;
            end
            if (rsp_fill) begin
                slot_q[fill_q]  <= SLOT_FILLED;
                instr_q[fill_q] <= imem_rsp_data;
                fill_q          <= fill_q + 1'b1;
            end
            // When full, tail aliases head; allocation must win over the pop's FREE.
            if (req_fire) begin
                slot_q[tail_q] <= SLOT_PENDING;
                pc_q[tail_q]   <= fetch_pc_q;
                tail_q         <= tail_q + 1'b1;
                fetch_pc_q     <= fetch_pc_q + 32'd4;
            end
            occ_q  <= occ_q + CW'(req_fire) - CW'(pop);
            pend_q <= pend_q + CW'(req_fire) - CW'(rsp_fill);
            drop_q <= drop_q - CW'(rsp_drop);
            if (rsp_spur) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - scoreboard bench for fetch_prefetch_queue
module tb_fetch_prefetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;
    logic [2:0]  occupancy;
    logic        protocol_err;

    fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_ready(out_ready), .occupancy(occupancy), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          req_cnt = 0;
    int          first_pop = -1;
    int          last_pop = -1;
    logic        rsp_en = 1'b0;
    logic        spur = 1'b0;

    function automatic logic [31:0] mk(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'hA5A5_0F0F;
    endfunction

    always @(posedge clk) cyc++;

    // Memory model: accepts at the handshake, answers in order one cycle later.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            mem_q.delete();
        end else if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back(imem_req_addr);
            req_cnt++;
        end
        @(posedge clk);
        #2;
        if (spur) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end else if (rsp_en && mem_q.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mk(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
        end
    end

    // Output monitor
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (reset && out_valid && out_ready) begin
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pop: got pc %h instr %h, nothing expected", out_pc, out_instr);
            end else begin
                e = exp_q.pop_front();
                if (out_pc !== e.pc || out_instr !== e.instr) begin
                    miscompares++;
                    $display("FAIL pop: got pc %h instr %h, expected pc %h instr %h",
                             out_pc, out_instr, e.pc, e.instr);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pc    = start + 32'(4 * i);
            e.instr = mk(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: %0d pops outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        out_ready = 1'b0;
    endtask

    // Leaves the bench at the start of the first cycle with reset released.
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0; redirect = 1'b0; spur = 1'b0; rsp_en = 1'b0;
        imem_req_ready = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_occupancy", 32'(occupancy), 32'h0);
        chk("rst_protocol_err", 32'(protocol_err), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        int c0;
        int base;

        // Streaming at one instruction per cycle
        do_reset();
        c0 = cyc;
        imem_req_ready = 1'b1; rsp_en = 1'b1; out_ready = 1'b1;
        first_pop = -1;
        expect_seq(32'h0, 16);
        drain("stream", 60);
        chk("stream_latency", 32'(first_pop - c0), 32'd2);
        chk("stream_rate", 32'(last_pop - first_pop), 32'd15);

        // Decode stall fills the queue, then resumes in order
        do_reset();
        base = req_cnt;
        imem_req_ready = 1'b1; rsp_en = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2) chk("stall_out_pc", out_pc, 32'h0);
        end
        chk("stall_req_cnt", 32'(req_cnt - base), 32'd4);
        chk("stall_req_valid", 32'(imem_req_valid), 32'h0);
        chk("stall_occupancy", 32'(occupancy), 32'd4);
        chk("stall_out_instr", out_instr, mk(32'h0));
        @(posedge clk); #1;
        expect_seq(32'h0, 8);
        out_ready = 1'b1;
        drain("stall", 60);

        // Redirect with three fetches in flight
        do_reset();
        imem_req_ready = 1'b1; rsp_en = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        @(negedge clk);
        chk("redir_req_valid", 32'(imem_req_valid), 32'h0);
        chk("redir_out_valid", 32'(out_valid), 32'h0);
        @(posedge clk); #1;
        redirect = 1'b0; rsp_en = 1'b1;
        expect_seq(32'h100, 4);
        @(negedge clk);
        chk("redir_next_addr", imem_req_addr, 32'h100);
        drain("redir", 60);

        // Redirect with a response on the redirect cycle
        do_reset();
        imem_req_ready = 1'b1; rsp_en = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        imem_req_ready = 1'b0;
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 32'h0000_0200; rsp_en = 1'b1;
        @(posedge clk); #1;
        redirect = 1'b0; imem_req_ready = 1'b1;
        expect_seq(32'h200, 3);
        @(negedge clk);
        chk("redir_rsp_addr", imem_req_addr, 32'h200);
        drain("redir_rsp", 60);

        // Memory backpressure holds the request stable
        do_reset();
        imem_req_ready = 1'b1; rsp_en = 1'b1; out_ready = 1'b1;
        expect_seq(32'h0, 8);
        repeat (2) @(posedge clk);
        #1;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_req_valid", 32'(imem_req_valid), 32'h1);
            chk("bp_req_addr", imem_req_addr, 32'h8);
            @(posedge clk); #1;
        end
        imem_req_ready = 1'b1;
        drain("bp", 60);

        // Spurious response sets a sticky error; reset clears it
        do_reset();
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        @(negedge clk);
        chk("spur_err_set", 32'(protocol_err), 32'h1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("spur_err_sticky", 32'(protocol_err), 32'h1);
        do_reset();
        @(negedge clk);
        chk("spur_err_clear", 32'(protocol_err), 32'h0);
        chk("post_rst_req_valid", 32'(imem_req_valid), 32'h1);
        chk("post_rst_req_addr", imem_req_addr, 32'h0);

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
